// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and defaults for the pipeline stall/flush control.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam int c_addr_w_def = 16;
    localparam int c_md_lat_def = 4;

    // Instruction word the IF/ID flush and ID/EX bubble logic load as a no-op
    localparam logic [15:0] c_nop_instr = 16'h0000;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_controller_md_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_wait_counter
//  Description : Loadable down-counter with zero flag for the mul/div wait.
//  Revision    : 1.0  initial release
// ============================================================================
module md_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule : md_wait_counter
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stall/flush sequencer for the 5-stage pipeline with a
//                saturating taken-branch flush counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def,
    parameter int MD_LAT = c_md_lat_def,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_use,
    input  logic              muldiv_start,
    input  logic              halt_dec,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              ex_hold,
    output logic              muldiv_done,
    output logic              halted,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int                c_cnt_w    = $clog2(MD_LAT);
    localparam logic [c_cnt_w-1:0] c_md_load = c_cnt_w'(MD_LAT - 2);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_flush_count;
    logic [c_cnt_w-1:0] w_md_count;
    logic               w_md_zero;
    logic               w_md_load;
    logic               w_md_dec;
    logic               w_flush_inc;

    logic               w_pc_we;
    logic               w_pc_sel;
    logic [ADDR_W-1:0]  w_pc_redirect;
    logic               w_ifid_we;
    logic               w_ifid_flush;
    logic               w_idex_bubble;
    logic               w_ex_hold;
    logic               w_muldiv_done;
    logic               w_halted;

    md_wait_counter #(
        .WIDTH (c_cnt_w)
    ) u_md_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_md_load),
        .i_load_val (c_md_load),
        .i_dec      (w_md_dec),
        .o_count    (w_md_count),
        .o_zero     (w_md_zero)
    );

    always_comb begin
        w_next        = r_state;
        w_md_load     = 1'b0;
        w_md_dec      = 1'b0;
        w_flush_inc   = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_sel      = 1'b0;
        w_pc_redirect = '0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_ex_hold     = 1'b0;
        w_muldiv_done = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_pc_we   = 1'b1;
                w_ifid_we = 1'b1;
                // Priority order keeps a redirect from ever pairing with a stall
                if (muldiv_start) begin
                    w_pc_we   = 1'b0;
                    w_ifid_we = 1'b0;
                    w_ex_hold = 1'b1;
                    w_md_load = 1'b1;
                    w_next    = ST_MD_WAIT;
                end else if (load_use) begin
                    w_pc_we       = 1'b0;
                    w_ifid_we     = 1'b0;
                    w_idex_bubble = 1'b1;
                end else if (halt_dec) begin
                    w_pc_we   = 1'b0;
                    w_ifid_we = 1'b0;
                    w_next    = ST_HALTED;
                end else if (branch_taken) begin
                    w_pc_sel      = 1'b1;
                    w_pc_redirect = branch_target;
                    w_ifid_flush  = 1'b1;
                    w_flush_inc   = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (w_md_zero) begin
                    w_muldiv_done = 1'b1;
                    w_next        = ST_RUN;
                end else begin
                    w_ex_hold = 1'b1;
                    w_md_dec  = 1'b1;
                end
            end
            ST_HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_flush_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_flush_inc && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    // Every output reads as zero for as long as reset is held
    assign pc_we       = rst_n & w_pc_we;
    assign pc_sel      = rst_n & w_pc_sel;
    assign pc_redirect = rst_n ? w_pc_redirect : '0;
    assign ifid_we     = rst_n & w_ifid_we;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign ex_hold     = rst_n & w_ex_hold;
    assign muldiv_done = rst_n & w_muldiv_done;
    assign halted      = rst_n & w_halted;
    assign state_o     = rst_n ? r_state : 2'b00;
    assign flush_count = rst_n ? r_flush_count : '0;

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed vector bench for pipeline_hazard_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    typedef struct {
        logic        rst_n;
        logic        bt;
        logic [15:0] tgt;
        logic        lu;
        logic        ms;
        logic        hd;
        logic [41:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        load_use;
    logic        muldiv_start;
    logic        halt_dec;

    logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, ex_hold, muldiv_done, halted;
    logic [15:0] pc_redirect;
    logic [1:0]  state_o;
    logic [15:0] flush_count;

    logic        s_pc_we, s_pc_sel, s_ifid_we, s_ifid_flush, s_idex_bubble, s_ex_hold, s_muldiv_done, s_halted;
    logic [15:0] s_pc_redirect;
    logic [1:0]  s_state_o;
    logic [3:0]  s_flush_count;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    pipeline_hazard_controller #(.ADDR_W(16), .MD_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
        .load_use(load_use), .muldiv_start(muldiv_start), .halt_dec(halt_dec),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_redirect(pc_redirect), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
        .muldiv_done(muldiv_done), .halted(halted), .state_o(state_o), .flush_count(flush_count)
    );

    // Narrow-counter instance used to reach saturation quickly
    pipeline_hazard_controller #(.ADDR_W(16), .MD_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
        .load_use(load_use), .muldiv_start(muldiv_start), .halt_dec(halt_dec),
        .pc_we(s_pc_we), .pc_sel(s_pc_sel), .pc_redirect(s_pc_redirect), .ifid_we(s_ifid_we),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .ex_hold(s_ex_hold),
        .muldiv_done(s_muldiv_done), .halted(s_halted), .state_o(s_state_o), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic bt, input logic [15:0] tgt, input logic lu,
                           input logic ms, input logic hd, input logic pw, input logic ps,
                           input logic [15:0] rd, input logic iw, input logic ifl, input logic bub,
                           input logic eh, input logic md, input logic hl, input logic [1:0] st,
                           input logic [15:0] fc);
        vec_t v;
        v.rst_n = r; v.bt = bt; v.tgt = tgt; v.lu = lu; v.ms = ms; v.hd = hd;
        v.exp = {pw, ps, rd, iw, ifl, bub, eh, md, hl, st, fc};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        load_use = 1'b0; muldiv_start = 1'b0; halt_dec = 1'b0;

        //       rst bt tgt       lu ms hd | pw ps redir     iw fl bb eh md hl st    fc
        add_vec(0, 1, 16'h0040, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        for (int i = 0; i < 5; i++)
            add_vec(1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 1, 16'h0040, 0, 0, 0,   1, 1, 16'h0040, 1, 1, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd1);
        add_vec(1, 1, 16'h0080, 1, 0, 0,   0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 2'd0, 16'd1);
        add_vec(1, 1, 16'h0080, 0, 0, 0,   1, 1, 16'h0080, 1, 1, 0, 0, 0, 0, 2'd0, 16'd1);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd2);
        add_vec(1, 1, 16'h00C0, 0, 1, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd0, 16'd2);
        add_vec(1, 1, 16'h00C0, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd1, 16'd2);
        add_vec(1, 1, 16'h00C0, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd1, 16'd2);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd1, 16'd2);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd2);
        add_vec(1, 0, 16'h0000, 0, 1, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd0, 16'd2);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd1, 16'd2);
        add_vec(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 1, 16'h0100, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 1, 16'h0100, 0, 1, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 2'd2, 16'd0);
        add_vec(1, 0, 16'h0000, 1, 0, 1,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 2'd2, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 2'd2, 16'd0);
        add_vec(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 1, 16'h0200, 1, 1, 1,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 1, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd1, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2'd1, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd1, 16'd0);
        add_vec(1, 1, 16'h0300, 0, 0, 0,   1, 1, 16'h0300, 1, 1, 0, 0, 0, 0, 2'd0, 16'd0);
        add_vec(1, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 2'd0, 16'd1);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; branch_taken = vecs[i].bt; branch_target = vecs[i].tgt;
            load_use = vecs[i].lu; muldiv_start = vecs[i].ms; halt_dec = vecs[i].hd;
            #2;
            check($sformatf("vec%0d", i),
                  64'({pc_we, pc_sel, pc_redirect, ifid_we, ifid_flush, idex_bubble,
                       ex_hold, muldiv_done, halted, state_o, flush_count}),
                  64'(vecs[i].exp));
        end

        // Back-to-back taken branches: wide counter counts, narrow one saturates
        @(negedge clk);
        rst_n = 1'b0; branch_taken = 1'b0; load_use = 1'b0; muldiv_start = 1'b0; halt_dec = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #2;
            if (k == 14) check("sat_cnt_14", 64'(s_flush_count), 64'd14);
            if (k == 20) begin
                check("sat_cnt_hold", 64'(s_flush_count), 64'd15);
                check("wide_cnt_20", 64'(flush_count), 64'd20);
                check("sat_redirect", 64'({s_pc_sel, s_ifid_flush, s_pc_redirect}), 64'({1'b1, 1'b1, 16'h0040}));
            end
        end
        branch_taken = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline. Consumes the ID-stage branch decision (flush request), the load-use hazard detect, the EX-stage multi-cycle mul/div issue and the halt decode. Drives PC write/redirect, the IF/ID enable and flush, the ID/EX bubble and the EX hold. Also keeps a saturating flush counter for performance debug.

Parameters:
ADDR_W, 16, PC/branch target width
MD_LAT, 4, total EX-stage cycles of a mul/div op (legal range 2..15)
CNT_W, 16, width of flush_count

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
branch_taken  in  1  ID-stage branch/jump resolved taken (flush request)
branch_target  in  ADDR_W  redirect address, valid with branch_taken
load_use  in  1  ID instr sources rd of load currently in EX
muldiv_start  in  1  EX-stage mul/div issued this cycle
halt_dec  in  1  halt instruction decoded in ID
pc_we  out  1  PC register write enable
pc_sel  out  1  0 = PC+2, 1 = pc_redirect
pc_redirect  out  ADDR_W  redirect target
ifid_we  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  insert NOP into ID/EX
ex_hold  out  1  freeze ID/EX and EX/MEM, EX unit keeps running
muldiv_done  out  1  one-cycle pulse on last mul/div cycle
halted  out  1  core halted
state_o  out  2  FSM state (debug)
flush_count  out  CNT_W  number of taken-branch flushes, saturating

Behaviour:
- Reset is synchronous, active-low, with the clock and reset fixed as stated above. On reset: state=RUN, wait counter=0, flush_count=0. While rst_n=0, all outputs are 0 (pc_we=0, ifid_we=0) and pc_redirect=0.
- FSM states (2-bit): RUN=0, MD_WAIT=1, HALTED=2. Encoding 3 is illegal and goes to RUN.
- Outputs are Mealy (combinational from state plus current inputs). State, counter and flush_count are registered.
- RUN defaults: pc_we=1, ifid_we=1, pc_sel=0, and all others 0.
- RUN priority, highest first: muldiv_start > load_use > halt_dec > branch_taken.
  - muldiv_start=1: pc_we=0, ifid_we=0, ex_hold=1. Load counter with MD_LAT-2. Next state MD_WAIT. The ID-stage branch/halt is not acted on; it re-evaluates after the wait.
  - load_use=1: one-cycle stall. pc_we=0, ifid_we=0, idex_bubble=1. Branch and halt are ignored this cycle because the compare operand is not yet valid. State stays RUN.
  - halt_dec=1: pc_we=0, ifid_we=0, idex_bubble=0. Next state HALTED.
  - branch_taken=1: pc_sel=1, pc_redirect=branch_target, ifid_flush=1, pc_we=1. Same-cycle redirect, so the branch penalty is 1 cycle. flush_count increments by 1 and saturates at all-ones.
- MD_WAIT: pc_we=0, ifid_we=0, ex_hold=1. All request inputs are ignored. Counter decrements each cycle.
  - When counter==0: muldiv_done=1, ex_hold=0. Next state RUN. PC and IF/ID stay disabled this cycle, and normal issue resumes next cycle.
  - Total EX occupancy is exactly MD_LAT cycles, counting the start cycle.
- HALTED: pc_we=0, ifid_we=0, ex_hold=0, halted=1. Only reset exits this state. Instructions already in EX/MEM/WB drain normally.
- Branches that redirect in the same cycle as load_use are forbidden by priority. The verifier asserts that pc_sel=1 never coincides with pc_we=0.
- Reset asserted mid MD_WAIT: FSM goes to RUN on that edge with the counter cleared. muldiv_done is not pulsed.
- Invariants:
  - ifid_flush and ifid_we=0 are never both active.
  - idex_bubble implies ifid_we=0.
  - At most one of ifid_flush, idex_bubble and ex_hold is 1 in any cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MD_WAIT, HALTED)
  - ADDR_W default
  - MD_LAT default
  - the NOP encoding used by the flush/bubble consumers
- One sub-module is natural: md_wait_counter (load, decrement, zero flag; width $clog2(MD_LAT)). It is instantiated once.

Test Plan:
- Reset then idle (no requests, 5 cycles) -> pc_we=1, ifid_we=1, pc_sel=0, state_o=0, flush_count=0 every cycle.
- branch_taken=1 with branch_target=16'h0040 for 1 cycle -> same cycle pc_sel=1, pc_redirect=16'h0040, ifid_flush=1; flush_count 0 -> 1 on the next edge. Repeat 2^CNT_W+3 times -> flush_count holds 16'hFFFF.
- load_use=1 and branch_taken=1 in the same cycle, then load_use=0 with branch_taken=1 -> cycle 1: idex_bubble=1, pc_we=0, pc_sel=0; cycle 2: redirect taken, flush_count +1.
- muldiv_start=1 with MD_LAT=4 -> ex_hold=1 for cycles 0-2, muldiv_done=1 on cycle 3 with ex_hold=0, pc_we=1 on cycle 4. branch_taken pulses during the wait are ignored.
- rst_n=0 during cycle 2 of MD_WAIT -> next cycle state_o=0, no muldiv_done pulse, flush_count=0.
- halt_dec=1 -> halted=1 and pc_we=0 indefinitely, ignoring branch/muldiv inputs. The state clears only after rst_n=0.
